// File: rtl/keypad_fsm_controller.sv
// Multi-tap 4x4 keypad scanner and letter/word entry FSM for the word-game core.
// Optional macro KEYPAD_DEBOUNCE_EN requires 4 identical synced row samples before a change is accepted.
module keypad_fsm_controller #(
    parameter int SCAN_DIV    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] read_row,
    output logic [3:0] scan_col,
    output logic [7:0] data,
    output logic       ready,
    output logic       toggle_state,
    output logic       game_end
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LETTER,
        ST_READY,
        ST_WORD,
        ST_END
    } state_t;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_LETTER,
        KEY_CLEAR,
        KEY_SUBLET,
        KEY_SUBWORD,
        KEY_END
    } key_t;

    logic [3:0]       r_sync [SYNC_STAGES];
    logic [3:0]       w_syncRow;
    logic [3:0]       w_row;
    logic [3:0]       r_rowPrev;
    logic             w_keyEvent;
    logic [3:0]       r_scanCol;
    logic [DIV_W-1:0] r_divCnt;
    logic [1:0]       w_colIdx;
    logic [1:0]       w_rowIdx;
    logic             w_rowValid;
    key_t             w_keyKind;
    logic [7:0]       w_letterBase;
    logic [2:0]       w_letterCnt;
    logic [3:0]       w_keyId;
    logic [1:0]       w_tapNext;
    state_t           r_state;
    state_t           w_stateNext;
    logic [7:0]       r_letter;
    logic [3:0]       r_lastKey;
    logic [1:0]       r_tapIdx;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= read_row;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_syncRow = r_sync[SYNC_STAGES-1];

`ifdef KEYPAD_DEBOUNCE_EN
    // A new row value is only accepted once it has been seen on four consecutive cycles.
    logic [3:0] r_hist [3];
    logic [3:0] r_cleanRow;
    logic       w_stable;

    assign w_stable = (w_syncRow == r_hist[0]) && (r_hist[0] == r_hist[1]) &&
                      (r_hist[1] == r_hist[2]);
    assign w_row    = w_stable ? w_syncRow : r_cleanRow;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_hist[0]  <= '0;
            r_hist[1]  <= '0;
            r_hist[2]  <= '0;
            r_cleanRow <= '0;
        end else begin
            r_hist[0]  <= w_syncRow;
            r_hist[1]  <= r_hist[0];
            r_hist[2]  <= r_hist[1];
            r_cleanRow <= w_row;
        end
    end
`else
    assign w_row = w_syncRow;
`endif

    assign w_keyEvent = (w_row != 4'd0) && (r_rowPrev == 4'd0);

    // Column drive rotates C0->C3 (bit3->bit0) and holds while a row reads active.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_rowPrev <= '0;
            r_scanCol <= 4'b1000;
            r_divCnt  <= '0;
        end else begin
            r_rowPrev <= w_row;
            if (w_row != 4'd0) begin
                r_divCnt <= '0;
            end else if (r_divCnt == DIV_W'(SCAN_DIV - 1)) begin
                r_divCnt  <= '0;
                r_scanCol <= {r_scanCol[0], r_scanCol[3:1]};
            end else begin
                r_divCnt <= r_divCnt + 1'b1;
            end
        end
    end

    assign scan_col = r_scanCol;

    always_comb begin
        w_colIdx   = 2'd3;
        w_rowIdx   = 2'd0;
        w_rowValid = 1'b1;
        case (r_scanCol)
            4'b1000: w_colIdx = 2'd0;
            4'b0100: w_colIdx = 2'd1;
            4'b0010: w_colIdx = 2'd2;
            default: w_colIdx = 2'd3;
        endcase
        case (w_row)
            4'b1000: w_rowIdx = 2'd0;
            4'b0100: w_rowIdx = 2'd1;
            4'b0010: w_rowIdx = 2'd2;
            4'b0001: w_rowIdx = 2'd3;
            default: w_rowValid = 1'b0;
        endcase
    end

    assign w_keyId = {w_rowIdx, w_colIdx};

    // Key map: {row, col} -> function, with the first ASCII letter and set size for letter keys.
    always_comb begin
        w_keyKind    = KEY_NONE;
        w_letterBase = 8'd0;
        w_letterCnt  = 3'd0;
        if (w_rowValid) begin
            case (w_keyId)
                4'b00_01: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd65; w_letterCnt = 3'd3; end
                4'b00_10: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd68; w_letterCnt = 3'd3; end
                4'b01_00: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd71; w_letterCnt = 3'd3; end
                4'b01_01: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd74; w_letterCnt = 3'd3; end
                4'b01_10: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd77; w_letterCnt = 3'd3; end
                4'b10_00: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd80; w_letterCnt = 3'd4; end
                4'b10_01: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd84; w_letterCnt = 3'd3; end
                4'b10_10: begin w_keyKind = KEY_LETTER; w_letterBase = 8'd87; w_letterCnt = 3'd4; end
                4'b10_11: w_keyKind = KEY_END;
                4'b11_00: w_keyKind = KEY_CLEAR;
                4'b11_01: w_keyKind = KEY_SUBLET;
                4'b11_10: w_keyKind = KEY_SUBWORD;
                default:  w_keyKind = KEY_NONE;
            endcase
        end
    end

    assign w_tapNext = ((3'(r_tapIdx) + 3'd1) >= w_letterCnt) ? 2'd0 : (r_tapIdx + 2'd1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_INIT: begin
                if (w_keyEvent) begin
                    case (w_keyKind)
                        KEY_LETTER:  w_stateNext = ST_LETTER;
                        KEY_END:     w_stateNext = ST_END;
                        KEY_SUBWORD: w_stateNext = ST_WORD;
                        default:     w_stateNext = ST_INIT;
                    endcase
                end
            end
            ST_LETTER: begin
                if (w_keyEvent) begin
                    case (w_keyKind)
                        KEY_CLEAR:   w_stateNext = ST_INIT;
                        KEY_SUBLET:  w_stateNext = ST_READY;
                        KEY_SUBWORD: w_stateNext = ST_WORD;
                        KEY_END:     w_stateNext = ST_END;
                        default:     w_stateNext = ST_LETTER;
                    endcase
                end
            end
            ST_READY: w_stateNext = ST_INIT;
            ST_WORD:  w_stateNext = ST_INIT;
            ST_END:   w_stateNext = ST_END;
            default:  w_stateNext = ST_INIT;
        endcase
    end

    // Multi-tap memory: forgotten in INIT, advanced on a repeat tap, restarted on a new letter key.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_letter  <= '0;
            r_lastKey <= '0;
            r_tapIdx  <= '0;
        end else if (w_stateNext == ST_INIT) begin
            r_letter  <= '0;
            r_lastKey <= '0;
            r_tapIdx  <= '0;
        end else if (w_keyEvent && (w_keyKind == KEY_LETTER) &&
                     ((r_state == ST_INIT) || (r_state == ST_LETTER))) begin
            r_lastKey <= w_keyId;
            if ((r_state == ST_LETTER) && (w_keyId == r_lastKey)) begin
                r_tapIdx <= w_tapNext;
                r_letter <= w_letterBase + 8'(w_tapNext);
            end else begin
                r_tapIdx <= 2'd0;
                r_letter <= w_letterBase;
            end
        end
    end

    always_comb begin
        data         = 8'd0;
        ready        = 1'b0;
        toggle_state = 1'b0;
        game_end     = 1'b0;
        case (r_state)
            ST_LETTER: data = r_letter;
            ST_READY: begin
                data  = r_letter;
                ready = 1'b1;
            end
            ST_WORD:  toggle_state = 1'b1;
            ST_END:   game_end = 1'b1;
            default:  data = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_keypad_fsm_controller.sv
// Self-checking bench for keypad_fsm_controller: directed test-plan presses plus random keys,
// compared against a string-based multi-tap model of the keypad game rules.
module tb_keypad_fsm_controller;

    localparam int SYNC = 2;

    logic       clk;
    logic       nRst;
    logic [3:0] read_row;
    logic [3:0] scan_col;
    logic [7:0] data;
    logic       ready;
    logic       toggle_state;
    logic       game_end;

    int passCount = 0;
    int failCount = 0;

    // Reference model state: letter mode, current letter set and tap position, sticky end flag.
    bit         mLetter;
    bit         mEnd;
    string      mSet;
    int         mTap;
    logic [7:0] expData;
    logic [7:0] pulseData;
    logic       expReady;
    logic       expToggle;

    keypad_fsm_controller #(.SCAN_DIV(1), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .read_row     (read_row),
        .scan_col     (scan_col),
        .data         (data),
        .ready        (ready),
        .toggle_state (toggle_state),
        .game_end     (game_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic string keyLabel(input int r, input int c);
        case (r * 4 + c)
            1:       return "ABC";
            2:       return "DEF";
            4:       return "GHI";
            5:       return "JKL";
            6:       return "MNO";
            8:       return "PQRS";
            9:       return "TUV";
            10:      return "WXYZ";
            11:      return "#END";
            12:      return "#CLR";
            13:      return "#SUBL";
            14:      return "#SUBW";
            default: return "";
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mLetter   = 0;
        mEnd      = 0;
        mSet      = "";
        mTap      = 0;
        expData   = 8'd0;
        pulseData = 8'd0;
        expReady  = 1'b0;
        expToggle = 1'b0;
    endtask

    task automatic modelKey(input int col, input logic [3:0] rowBits);
        int    rowIdx;
        string lbl;
        rowIdx    = -1;
        lbl       = "";
        expReady  = 1'b0;
        expToggle = 1'b0;
        if ($countones(rowBits) == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (rowBits[3-i]) rowIdx = i;
            end
            lbl = keyLabel(rowIdx, col);
        end
        if (!mEnd) begin
            if (lbl == "#END") begin
                mEnd    = 1;
                mLetter = 0;
            end else if (lbl == "#SUBW") begin
                expToggle = 1'b1;
                mLetter   = 0;
            end else if (lbl == "#CLR") begin
                mLetter = 0;
            end else if (lbl == "#SUBL") begin
                if (mLetter) begin
                    expReady  = 1'b1;
                    pulseData = mSet[mTap];
                    mLetter   = 0;
                end
            end else if (lbl != "") begin
                if (mLetter && (lbl == mSet)) begin
                    mTap = (mTap + 1) % mSet.len();
                end else begin
                    mSet = lbl;
                    mTap = 0;
                end
                mLetter = 1;
            end
        end
        expData = mLetter ? mSet[mTap] : 8'd0;
        if (!expReady) pulseData = expData;
    endtask

    // Press and release one key position; the bench starts each press just after a rising edge.
    task automatic applyStimulus(input int col, input logic [3:0] rowBits);
        logic [3:0] want;
        logic [3:0] keyCol;
        logic [7:0] prevData;
        int         guard;
        keyCol = 4'b1000 >> col;
        want   = 4'b1000 >> ((col + 4 - SYNC) % 4);
        guard  = 0;
        while (scan_col !== want && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("align", {4'd0, scan_col}, {4'd0, want});
        prevData = expData;
        modelKey(col, rowBits);
        read_row = rowBits;
        repeat (SYNC) @(posedge clk);
        #1;
        checkOutput("latency", data, prevData);
        @(posedge clk);
        #1;
        checkOutput("data", data, pulseData);
        checkOutput("ready", {7'd0, ready}, {7'd0, expReady});
        checkOutput("toggle", {7'd0, toggle_state}, {7'd0, expToggle});
        checkOutput("game_end", {7'd0, game_end}, {7'd0, mEnd});
        checkOutput("frozen_col", {4'd0, scan_col}, {4'd0, keyCol});
        @(posedge clk);
        #1;
        checkOutput("ready_drop", {7'd0, ready}, 8'd0);
        checkOutput("toggle_drop", {7'd0, toggle_state}, 8'd0);
        checkOutput("data_after", data, expData);
        read_row = 4'd0;
        repeat (SYNC + 2) @(posedge clk);
        #1;
    endtask

    task automatic pressRC(input int r, input int c);
        applyStimulus(c, 4'b1000 >> r);
    endtask

    initial begin
        int         col;
        int         row;
        logic [3:0] bits;

        modelReset();
        nRst     = 1'b0;
        read_row = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data", data, 8'd0);
        checkOutput("rst_ready", {7'd0, ready}, 8'd0);
        checkOutput("rst_toggle", {7'd0, toggle_state}, 8'd0);
        checkOutput("rst_game_end", {7'd0, game_end}, 8'd0);
        checkOutput("rst_scan", {4'd0, scan_col}, 8'b0000_1000);
        nRst = 1'b1;
        #1;
        checkOutput("rel_data", data, 8'd0);
        checkOutput("rel_scan", {4'd0, scan_col}, 8'b0000_1000);
        read_row = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle_data", data, 8'd0);

        for (int i = 0; i < 4; i++) pressRC(0, 2);
        checkOutput("plan_D_wrap", data, 8'd68);
        for (int i = 0; i < 5; i++) pressRC(2, 0);
        checkOutput("plan_P_wrap", data, 8'd80);
        pressRC(1, 0);
        pressRC(0, 1);
        checkOutput("plan_A", data, 8'd65);
        pressRC(1, 0);
        checkOutput("plan_G", data, 8'd71);

        pressRC(1, 1);
        pressRC(0, 0);
        checkOutput("plan_J_hold", data, 8'd74);
        pressRC(3, 1);
        pressRC(3, 1);

        pressRC(1, 0);
        pressRC(3, 0);
        checkOutput("plan_clear", data, 8'd0);
        pressRC(1, 2);
        checkOutput("plan_M", data, 8'd77);

        pressRC(2, 0);
        pressRC(3, 2);

        for (int i = 0; i < 30; i++) begin
            col = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                bits = 4'($urandom_range(3, 15));
                while ($countones(bits) < 2) bits = 4'($urandom_range(3, 15));
                applyStimulus(col, bits);
            end else begin
                row = $urandom_range(0, 3);
                if (row == 2 && col == 3) col = 2;
                pressRC(row, col);
            end
        end

        pressRC(0, 1);
        nRst = 1'b0;
        #1;
        modelReset();
        checkOutput("midrst_data", data, 8'd0);
        checkOutput("midrst_scan", {4'd0, scan_col}, 8'b0000_1000);
        #3;
        nRst = 1'b1;
        @(posedge clk);
        #1;
        pressRC(0, 1);
        checkOutput("after_rst_A", data, 8'd65);

        pressRC(1, 2);
        pressRC(2, 3);
        checkOutput("plan_end", {7'd0, game_end}, 8'd1);
        pressRC(1, 2);
        pressRC(1, 2);
        checkOutput("plan_end_data", data, 8'd0);
        checkOutput("plan_end_sticky", {7'd0, game_end}, 8'd1);

        nRst = 1'b0;
        #1;
        modelReset();
        checkOutput("end_rst", {7'd0, game_end}, 8'd0);
        nRst = 1'b1;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, passCount + failCount);
        $finish;
    end

endmodule
